// File: rtl/power_monitor_scan.sv
// rtl/power_monitor_scan.sv - window-comparator power monitor with debounced pgood/fault and scan tracking
//
// Purpose:
//   Classifies tagged ADC samples against per-channel UV/OV thresholds and
//   derived warn bands. Each channel is debounced into pgood/fault flags.
//   A scan mask produces a one-cycle end-of-scan pulse once every converter
//   has been sampled.
//   Build option PMON_FAULT_LATCH_EN: per-channel faults are sticky until
//   fault_clr. Without it, a channel's fault clears when the channel
//   re-debounces good.
// Ports:
//   clock, reset_n        clock and synchronous active-low reset
//   enable                0 idles the monitor and clears counters, mask and pgood
//   sample_valid/chan/data tagged ADC sample
//   cfg_we/sel/chan/wdata threshold write (sel 0: UV, sel 1: OV)
//   fault_clr             clears the captured fault channel (and sticky faults)
//   fault, fault_chan     any channel faulted / first faulted channel since clear
//   warn                  any channel's last sample in its warn band
//   eoc                   one-cycle pulse when all channels have been seen
//   pgood_bus             AND of all channels in bit 0, or the per-channel bus
module power_monitor_scan #(
  parameter int NUM_CONVERTERS = 8,
  parameter int DATA_WIDTH     = 12,
  parameter int DEBOUNCE       = 4,
  parameter int WARN_MARGIN    = 16,
  parameter int PGOOD_MODE     = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic [4:0]            sample_chan,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [4:0]            cfg_chan,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  input  logic                  fault_clr,
  output logic                  fault,
  output logic [4:0]            fault_chan,
  output logic                  warn,
  output logic                  eoc,
  output logic [31:0]           pgood_bus
);
  localparam int CW  = (NUM_CONVERTERS > 1) ? $clog2(NUM_CONVERTERS) : 1;
  localparam int DW1 = DATA_WIDTH + 1;
  localparam int DW2 = DATA_WIDTH + 2;
  localparam logic [3:0] DEB  = 4'(DEBOUNCE);
  localparam logic [5:0] NUM6 = 6'(NUM_CONVERTERS);

  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0]     uv_thr   [NUM_CONVERTERS];
  logic [DATA_WIDTH-1:0]     ov_thr   [NUM_CONVERTERS];
  logic [3:0]                good_cnt [NUM_CONVERTERS];
  logic [3:0]                bad_cnt  [NUM_CONVERTERS];
  logic [NUM_CONVERTERS-1:0] seen;
  logic [NUM_CONVERTERS-1:0] pgood;
  logic [NUM_CONVERTERS-1:0] flt;
  logic [NUM_CONVERTERS-1:0] wrn;
  logic                      fc_held;

  logic [CW-1:0]             s_idx;
  logic [CW-1:0]             c_idx;
  logic                      chan_ok;
  logic                      cfg_ok;
  logic [DATA_WIDTH-1:0]     uv_c;
  logic [DATA_WIDTH-1:0]     ov_c;
  logic [DW2-1:0]            uv_sum;
  logic [DW1-1:0]            uv_band;
  logic [DW1-1:0]            ov_band;
  logic [DW1-1:0]            s_ext;
  logic                      is_fault;
  logic                      is_warn;
  logic [3:0]                good_nxt;
  logic [3:0]                bad_nxt;
  logic [NUM_CONVERTERS-1:0] seen_nxt;
  logic [NUM_CONVERTERS-1:0] flt_base;
  logic                      fc_held_base;
  logic [4:0]                fault_chan_base;

  assign s_idx   = sample_chan[CW-1:0];
  assign c_idx   = cfg_chan[CW-1:0];
  assign chan_ok = ({1'b0, sample_chan} < NUM6);
  assign cfg_ok  = ({1'b0, cfg_chan} < NUM6);
  assign uv_c    = uv_thr[s_idx];
  assign ov_c    = ov_thr[s_idx];

  // Warn band edges are computed one bit wider than the data so that the
  // UV side cannot wrap and the OV side floors at zero.
  assign uv_sum   = DW2'(uv_c) + DW2'(WARN_MARGIN);
  assign uv_band  = uv_sum[DW1] ? {DW1{1'b1}} : uv_sum[DW1-1:0];
  assign ov_band  = (DW1'(ov_c) < DW1'(WARN_MARGIN)) ? '0 : DW1'(ov_c) - DW1'(WARN_MARGIN);
  assign s_ext    = DW1'(sample_data);
  assign is_fault = (sample_data < uv_c) || (sample_data > ov_c);
  assign is_warn  = !is_fault && ((s_ext < uv_band) || (s_ext > ov_band));

  assign good_nxt = is_fault ? 4'd0 :
                    ((good_cnt[s_idx] >= DEB) ? DEB : good_cnt[s_idx] + 4'd1);
  assign bad_nxt  = !is_fault ? 4'd0 :
                    ((bad_cnt[s_idx] >= DEB) ? DEB : bad_cnt[s_idx] + 4'd1);
  assign seen_nxt = seen | (NUM_CONVERTERS'(1) << s_idx);

  // State as seen after fault_clr; a fault raised at the same edge is
  // applied on top of this, so the new fault wins over the clear.
`ifdef PMON_FAULT_LATCH_EN
  assign flt_base = fault_clr ? '0 : flt;
`else
  assign flt_base = flt;
`endif
  assign fc_held_base    = fault_clr ? 1'b0 : fc_held;
  assign fault_chan_base = fault_clr ? 5'd0 : fault_chan;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      seen       <= '0;
      pgood      <= '0;
      flt        <= '0;
      wrn        <= '0;
      fc_held    <= 1'b0;
      fault_chan <= 5'd0;
      eoc        <= 1'b0;
      for (int i = 0; i < NUM_CONVERTERS; i++) begin
        uv_thr[i]   <= '0;
        ov_thr[i]   <= '1;
        good_cnt[i] <= 4'd0;
        bad_cnt[i]  <= 4'd0;
      end
    end else begin
      eoc        <= 1'b0;
      flt        <= flt_base;
      fc_held    <= fc_held_base;
      fault_chan <= fault_chan_base;

      // Threshold writes land at this edge; a sample this cycle still
      // classified against the old value above.
      if (cfg_we && cfg_ok) begin
        if (cfg_sel) ov_thr[c_idx] <= cfg_wdata;
        else         uv_thr[c_idx] <= cfg_wdata;
      end

      case (state)
        IDLE: begin
          if (enable) state <= SCAN;
        end
        SCAN: begin
          if (!enable) begin
            state <= IDLE;
            seen  <= '0;
            pgood <= '0;
            wrn   <= '0;
            for (int i = 0; i < NUM_CONVERTERS; i++) begin
              good_cnt[i] <= 4'd0;
              bad_cnt[i]  <= 4'd0;
            end
          end else if (sample_valid && chan_ok) begin
            good_cnt[s_idx] <= good_nxt;
            bad_cnt[s_idx]  <= bad_nxt;
            wrn[s_idx]      <= is_warn;
            if (!is_fault && good_nxt == DEB) begin
`ifdef PMON_FAULT_LATCH_EN
              // A sticky fault holds pgood low until it has been cleared.
              if (!flt_base[s_idx]) pgood[s_idx] <= 1'b1;
`else
              pgood[s_idx] <= 1'b1;
              flt[s_idx]   <= 1'b0;
`endif
            end
            if (is_fault && bad_nxt == DEB) begin
              pgood[s_idx] <= 1'b0;
              flt[s_idx]   <= 1'b1;
              if (!fc_held_base) begin
                fault_chan <= sample_chan;
                fc_held    <= 1'b1;
              end
            end
            if (&seen_nxt) begin
              eoc  <= 1'b1;
              seen <= '0;
            end else begin
              seen <= seen_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fault = |flt;
  assign warn  = |wrn;

  generate
    if (PGOOD_MODE == 0) begin : g_pgood_and
      assign pgood_bus = {31'b0, &pgood};
    end else begin : g_pgood_bus
      assign pgood_bus = 32'(pgood);
    end
  endgenerate
endmodule

// File: tb/tb_power_monitor_scan.sv
// tb/tb_power_monitor_scan.sv - table-driven and randomized bench for power_monitor_scan
module tb_power_monitor_scan;
  localparam int NUM = 8;
  localparam int DEB = 4;
  localparam int WM  = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sample_valid;
  logic [4:0]  sample_chan;
  logic [11:0] sample_data;
  logic        cfg_we;
  logic        cfg_sel;
  logic [4:0]  cfg_chan;
  logic [11:0] cfg_wdata;
  logic        fault_clr;

  logic        fault0, fault1, warn0, warn1, eoc0, eoc1;
  logic [4:0]  fch0, fch1;
  logic [31:0] pg0, pg1;

  int nerr = 0;
  int nchk = 0;

  always #5 clock = ~clock;

  power_monitor_scan #(.NUM_CONVERTERS(NUM), .DATA_WIDTH(12), .DEBOUNCE(DEB),
                       .WARN_MARGIN(WM), .PGOOD_MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .sample_chan(sample_chan), .sample_data(sample_data), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_chan(cfg_chan), .cfg_wdata(cfg_wdata),
    .fault_clr(fault_clr), .fault(fault0), .fault_chan(fch0), .warn(warn0),
    .eoc(eoc0), .pgood_bus(pg0));

  power_monitor_scan #(.NUM_CONVERTERS(NUM), .DATA_WIDTH(12), .DEBOUNCE(DEB),
                       .WARN_MARGIN(WM), .PGOOD_MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .sample_chan(sample_chan), .sample_data(sample_data), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_chan(cfg_chan), .cfg_wdata(cfg_wdata),
    .fault_clr(fault_clr), .fault(fault1), .fault_chan(fch1), .warn(warn1),
    .eoc(eoc1), .pgood_bus(pg1));

  // Behavioural reference: per-channel integers and flags updated by the rules.
  int m_uv[NUM], m_ov[NUM], m_good[NUM], m_bad[NUM];
  bit m_pg[NUM], m_flt[NUM], m_wr[NUM], m_seen[NUM];
  bit m_scan, m_held, m_eoc;
  int m_fch;

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_uv[i] = 0; m_ov[i] = 4095; m_good[i] = 0; m_bad[i] = 0;
      m_pg[i] = 0; m_flt[i] = 0; m_wr[i] = 0; m_seen[i] = 0;
    end
    m_scan = 0; m_held = 0; m_eoc = 0; m_fch = 0;
  endtask

  task automatic model_step(input bit en, input bit sv, input int ch, input int d,
                            input bit we, input bit sel, input int cc, input int wd,
                            input bit clr);
    m_eoc = 0;
    if (clr) begin
`ifdef PMON_FAULT_LATCH_EN
      for (int i = 0; i < NUM; i++) m_flt[i] = 0;
`endif
      m_fch = 0; m_held = 0;
    end
    if (!m_scan) begin
      m_scan = en;
    end else if (!en) begin
      m_scan = 0;
      for (int i = 0; i < NUM; i++) begin
        m_seen[i] = 0; m_good[i] = 0; m_bad[i] = 0; m_pg[i] = 0; m_wr[i] = 0;
      end
    end else if (sv && ch < NUM) begin
      bit f, w, all;
      int wlo, whi;
      f   = (d < m_uv[ch]) || (d > m_ov[ch]);
      wlo = m_uv[ch] + WM;
      if (wlo > 8191) wlo = 8191;
      whi = m_ov[ch] - WM;
      if (whi < 0) whi = 0;
      w = !f && (d < wlo || d > whi);
      m_wr[ch] = w;
      if (f) begin
        m_good[ch] = 0;
        if (m_bad[ch] < DEB) m_bad[ch]++;
      end else begin
        m_bad[ch] = 0;
        if (m_good[ch] < DEB) m_good[ch]++;
      end
      if (!f && m_good[ch] == DEB) begin
`ifdef PMON_FAULT_LATCH_EN
        if (!m_flt[ch]) m_pg[ch] = 1;
`else
        m_pg[ch] = 1;
        m_flt[ch] = 0;
`endif
      end
      if (f && m_bad[ch] == DEB) begin
        m_pg[ch] = 0;
        m_flt[ch] = 1;
        if (!m_held) begin m_fch = ch; m_held = 1; end
      end
      m_seen[ch] = 1;
      all = 1;
      for (int i = 0; i < NUM; i++) if (!m_seen[i]) all = 0;
      if (all) begin
        m_eoc = 1;
        for (int i = 0; i < NUM; i++) m_seen[i] = 0;
      end
    end
    if (we && cc < NUM) begin
      if (sel) m_ov[cc] = wd;
      else     m_uv[cc] = wd;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    logic [31:0] pgv;
    bit f, w;
    pgv = 0; f = 0; w = 0;
    for (int i = 0; i < NUM; i++) begin
      pgv[i] = m_pg[i];
      f = f | m_flt[i];
      w = w | m_wr[i];
    end
    check({tag, " model pgood_bus mode1"}, pg1, pgv);
    check({tag, " model pgood_bus mode0"}, pg0, {31'b0, &pgv[NUM-1:0]});
    check({tag, " model fault"}, {30'b0, fault1, fault0}, {30'b0, f, f});
    check({tag, " model fault_chan"}, {22'b0, fch1, fch0}, 32'((m_fch << 5) | m_fch));
    check({tag, " model warn"}, {30'b0, warn1, warn0}, {30'b0, w, w});
    check({tag, " model eoc"}, {30'b0, eoc1, eoc0}, {30'b0, m_eoc, m_eoc});
  endtask

  task automatic cyc(input bit en, input bit sv, input int ch, input int d,
                     input bit we, input bit sel, input int cc, input int wd,
                     input bit clr, input string tag);
    enable = en; sample_valid = sv; sample_chan = 5'(ch); sample_data = 12'(d);
    cfg_we = we; cfg_sel = sel; cfg_chan = 5'(cc); cfg_wdata = 12'(wd); fault_clr = clr;
    model_step(en, sv, ch, d, we, sel, cc, wd, clr);
    @(posedge clock);
    #1;
    compare_model(tag);
  endtask

  typedef struct {
    bit en; bit sv; int ch; int d; bit we; bit sel; int cc; int wd; bit clr;
    logic [7:0] pg; bit flt; int fch; bit wrn; bit eoc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit en, input bit sv, input int ch, input int d,
                     input bit we, input bit sel, input int cc, input int wd, input bit clr,
                     input logic [7:0] pg, input bit flt, input int fch, input bit wrn, input bit eoc);
    vec_t v;
    v.en = en; v.sv = sv; v.ch = ch; v.d = d; v.we = we; v.sel = sel; v.cc = cc;
    v.wd = wd; v.clr = clr; v.pg = pg; v.flt = flt; v.fch = fch; v.wrn = wrn; v.eoc = eoc;
    tbl.push_back(v);
  endtask

  task automatic smp(input int ch, input int d, input logic [7:0] pg, input bit flt,
                     input int fch, input bit wrn, input bit eoc);
    add(1, 1, ch, d, 0, 0, 0, 0, 0, pg, flt, fch, wrn, eoc);
  endtask

  function automatic int clampd(input int v);
    if (v < 0) return 0;
    if (v > 4095) return 4095;
    return v;
  endfunction

  initial begin
    vec_t v;
    int c, r, lo, hi, d, cc, wd;
    bit en, sv, we, sel, clr;

    // Directed table; expected outputs are those visible right after each edge.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      for (int ch = 0; ch < 8; ch++)
        smp(ch, 2000, (k < 3) ? 8'h00 : 8'((1 << (ch + 1)) - 1), 0, 0, 0, ch == 7);
    for (int i = 0; i < 3; i++) smp(3, 3500, 8'hFF, 0, 0, 0, 0);
    smp(3, 3500, 8'hF7, 1, 3, 0, 0);
    for (int i = 0; i < 3; i++) smp(3, 2000, 8'hF7, 1, 3, 0, 0);
`ifdef PMON_FAULT_LATCH_EN
    smp(3, 2000, 8'hF7, 1, 3, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'hF7, 0, 0, 0, 0);
`else
    smp(3, 2000, 8'hFF, 0, 3, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0);
`endif
    smp(3, 2000, 8'hFF, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) smp(3, 3500, 8'hFF, 0, 0, 0, 0);
    smp(3, 2000, 8'hFF, 0, 0, 0, 0);
    smp(3, 3500, 8'hFF, 0, 0, 0, 0);
    smp(5, 1010, 8'hFF, 0, 0, 1, 0);
    smp(5, 2000, 8'hFF, 0, 0, 0, 0);
    smp(6, 2990, 8'hFF, 0, 0, 1, 0);
    smp(6, 2000, 8'hFF, 0, 0, 0, 0);
    smp(1, 1000, 8'hFF, 0, 0, 1, 0);
    smp(1, 3000, 8'hFF, 0, 0, 1, 0);
    smp(1,  999, 8'hFF, 0, 0, 0, 0);
    smp(1, 1016, 8'hFF, 0, 0, 0, 0);
    smp(1, 2984, 8'hFF, 0, 0, 0, 0);
    smp(1, 2985, 8'hFF, 0, 0, 1, 0);
    smp(1, 3001, 8'hFF, 0, 0, 0, 0);
    smp(1, 2000, 8'hFF, 0, 0, 0, 0);
    smp(9, 3500, 8'hFF, 0, 0, 0, 0);
    smp(8, 3500, 8'hFF, 0, 0, 0, 0);
    add(1, 1, 0, 2000, 1, 1, 0, 1500, 0, 8'hFF, 0, 0, 0, 0);
    smp(0, 2000, 8'hFF, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 3000, 0, 8'hFF, 0, 0, 0, 0);
    smp(2, 2000, 8'hFF, 0, 0, 0, 0);
    smp(4, 2000, 8'hFF, 0, 0, 0, 0);
    smp(7, 2000, 8'hFF, 0, 0, 0, 1);
    smp(0, 2000, 8'hFF, 0, 0, 0, 0);
    smp(1, 2000, 8'hFF, 0, 0, 0, 0);
    smp(2, 2000, 8'hFF, 0, 0, 0, 0);
    add(0, 1, 3, 2000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 7, 2000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int ch = 0; ch < 8; ch++) smp(ch, 2000, 8'h00, 0, 0, 0, ch == 7);
    for (int i = 0; i < 3; i++) smp(4, 3500, 8'h00, 0, 0, 0, 0);
    smp(4, 3500, 8'h00, 1, 4, 0, 0);
    for (int i = 0; i < 3; i++) smp(2, 3500, 8'h00, 1, 4, 0, 0);
    add(1, 1, 2, 3500, 0, 0, 0, 0, 1, 8'h00, 1, 2, 0, 0);
    smp(2, 3500, 8'h00, 1, 2, 0, 0);

    // Reset
    model_reset();
    reset_n = 1'b0; enable = 0; sample_valid = 0; sample_chan = 0; sample_data = 0;
    cfg_we = 0; cfg_sel = 0; cfg_chan = 0; cfg_wdata = 0; fault_clr = 0;
    repeat (3) @(posedge clock);
    #1;
    check("reset pgood_bus", pg0 | pg1, 32'h0);
    check("reset flags", {27'b0, fault1, warn1, eoc1, fault0, eoc0}, 32'h0);
    check("reset fault_chan", {27'b0, fch1}, 32'h0);
    compare_model("reset");
    reset_n = 1'b1;

    for (int ch = 0; ch < NUM; ch++) begin
      cyc(0, 0, 0, 0, 1, 0, ch, 1000, 0, "cfg");
      cyc(0, 0, 0, 0, 1, 1, ch, 3000, 0, "cfg");
    end

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      v = tbl[i];
      t = $sformatf("row%0d", i);
      cyc(v.en, v.sv, v.ch, v.d, v.we, v.sel, v.cc, v.wd, v.clr, t);
      check({t, " pgood_bus mode1"}, pg1, {24'b0, v.pg});
      check({t, " pgood_bus mode0"}, pg0, {31'b0, &v.pg});
      check({t, " fault"}, {31'b0, fault1}, {31'b0, v.flt});
      check({t, " fault_chan"}, {27'b0, fch1}, 32'(v.fch));
      check({t, " warn"}, {31'b0, warn1}, {31'b0, v.wrn});
      check({t, " eoc"}, {31'b0, eoc1}, {31'b0, v.eoc});
    end

    // Randomized traffic biased toward threshold edges, checked against the model.
    for (int n = 0; n < 3000; n++) begin
      c  = $urandom_range(0, 9);
      r  = $urandom_range(0, 9);
      lo = (c < NUM) ? m_uv[c] : 1000;
      hi = (c < NUM) ? m_ov[c] : 3000;
      case (r)
        0, 1, 2, 3: d = (hi - WM - 1 > lo + WM + 1) ? $urandom_range(lo + WM + 1, hi - WM - 1)
                                                    : $urandom_range(0, 4095);
        4:          d = clampd(lo - 3 + $urandom_range(0, WM + 6));
        5:          d = clampd(hi - WM - 3 + $urandom_range(0, WM + 6));
        6:          d = $urandom_range(0, 4095);
        default:    d = clampd((lo + hi) / 2);
      endcase
      en  = ($urandom_range(0, 99) != 0);
      sv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 39) == 0);
      sel = $urandom_range(0, 1);
      cc  = $urandom_range(0, 9);
      if (!sel)                             wd = $urandom_range(0, 1500);
      else if ($urandom_range(0, 9) == 0)   wd = $urandom_range(0, 20);
      else                                  wd = $urandom_range(2500, 4095);
      cyc(en, sv, c, d, we, sel, cc, wd, clr, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
